// File: rtl/spi_frame_rx.sv
// spi_frame_rx: synchronises raw SPI pins and deserialises command/payload frames into a valid/ready slot
module spi_frame_rx #(
  parameter int CMD_BITS = 4,
  parameter int DATA_MAX = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_sclk,
  input  logic                i_ss_n,
  input  logic                i_mosi,
  output logic [CMD_BITS-1:0] o_cmd,
  output logic [DATA_MAX-1:0] o_data,
  output logic                o_valid,
  input  logic                i_ready,
  output logic                o_busy,
  output logic                o_err_abort,
  output logic                o_err_cmd,
  output logic                o_overrun
);
  localparam int CW = $clog2((DATA_MAX > CMD_BITS ? DATA_MAX : CMD_BITS) + 1);

  typedef enum logic [1:0] {IDLE, CMD, DATA, DISCARD} state_t;

  state_t              state_q, state_d;
  logic [2:0]          sclk_buf_q;
  logic [1:0]          ss_buf_q, mosi_buf_q;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [CMD_BITS-1:0] cmd_sr_q, cmd_sr_d, cmd_next, cmd_q, cmd_d;
  logic [DATA_MAX-1:0] data_sr_q, data_sr_d, data_next, data_q, data_d;
  logic                valid_q, valid_d;
  logic                abort_q, abort_d, err_cmd_q, err_cmd_d, overrun_q, overrun_d;
  logic                rise, ss_active, mosi, frame_done, load;

  // Payload length per command; zero marks an invalid command.
  function automatic logic [CW-1:0] len_of(input logic [CMD_BITS-1:0] c);
    case (c)
      CMD_BITS'(0), CMD_BITS'(1), CMD_BITS'(2), CMD_BITS'(4): len_of = CW'(6);
      CMD_BITS'(3): len_of = CW'(12);
      CMD_BITS'(5): len_of = CW'(1);
      CMD_BITS'(6): len_of = CW'(16);
      default:      len_of = '0;
    endcase
  endfunction

  assign rise      = sclk_buf_q[2:1] == 2'b01;
  assign ss_active = ~ss_buf_q[1];
  assign mosi      = mosi_buf_q[1];
  assign cmd_next  = CMD_BITS'({cmd_sr_q, mosi});
  assign data_next = DATA_MAX'({data_sr_q, mosi});

  // Bring the asynchronous SPI pins into the clk domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_buf_q <= 3'b000;
      ss_buf_q   <= 2'b11;
      mosi_buf_q <= 2'b00;
    end else begin
      sclk_buf_q <= {sclk_buf_q[1:0], i_sclk};
      ss_buf_q   <= {ss_buf_q[0], i_ss_n};
      mosi_buf_q <= {mosi_buf_q[0], i_mosi};
    end
  end

  // Framing state, shift registers, output slot and error pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cmd_sr_q  <= '0;
      data_sr_q <= '0;
      cmd_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      abort_q   <= 1'b0;
      err_cmd_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cmd_sr_q  <= cmd_sr_d;
      data_sr_q <= data_sr_d;
      cmd_q     <= cmd_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      abort_q   <= abort_d;
      err_cmd_q <= err_cmd_d;
      overrun_q <= overrun_d;
    end
  end

  // Frame FSM: SS release wins in every state; otherwise each SCLK rise advances the frame.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_sr_d   = cmd_sr_q;
    data_sr_d  = data_sr_q;
    abort_d    = 1'b0;
    err_cmd_d  = 1'b0;
    frame_done = 1'b0;
    if (!ss_active) begin
      state_d = IDLE;
      cnt_d   = '0;
      abort_d = (state_q == CMD && cnt_q != '0) || state_q == DATA;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = CMD;
          cnt_d   = '0;
        end
        CMD: if (rise) begin
          cmd_sr_d = cmd_next;
          cnt_d    = cnt_q + CW'(1);
          if (cnt_q == CW'(CMD_BITS - 1)) begin
            cnt_d     = '0;
            data_sr_d = '0;
            state_d   = len_of(cmd_next) != '0 ? DATA : DISCARD;
            err_cmd_d = len_of(cmd_next) == '0;
          end
        end
        DATA: if (rise) begin
          data_sr_d = data_next;
          cnt_d     = cnt_q + CW'(1);
          if (cnt_q == len_of(cmd_sr_q) - CW'(1)) begin
            frame_done = 1'b1;
            state_d    = CMD;
            cnt_d      = '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Holding slot: a completed frame loads only if the slot is empty or being drained this cycle.
  always_comb begin
    load      = frame_done && (!valid_q || i_ready);
    cmd_d     = load ? cmd_sr_q : cmd_q;
    data_d    = load ? data_next : data_q;
    valid_d   = load || (valid_q && !i_ready);
    overrun_d = frame_done && !load;
  end

  assign o_cmd       = cmd_q;
  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_busy      = state_q != IDLE;
  assign o_err_abort = abort_q;
  assign o_err_cmd   = err_cmd_q;
  assign o_overrun   = overrun_q;
endmodule

// File: tb/tb_spi_frame_rx.sv
// tb_spi_frame_rx: directed table and corner-case sequences for spi_frame_rx
module tb_spi_frame_rx;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_sclk = 1'b0;
  logic        i_ss_n = 1'b1;
  logic        i_mosi = 1'b0;
  logic        i_ready = 1'b1;
  logic [3:0]  o_cmd;
  logic [15:0] o_data;
  logic        o_valid, o_busy, o_err_abort, o_err_cmd, o_overrun;

  int checks = 0;
  int errors = 0;
  int n_abort = 0;
  int n_cmderr = 0;
  int n_overrun = 0;
  logic [19:0] acc_q[$];

  typedef struct {
    logic [3:0]  cmd;
    int          len;
    logic [15:0] pay;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[7];

  spi_frame_rx dut (
    .clk(clk), .reset(reset), .i_sclk(i_sclk), .i_ss_n(i_ss_n), .i_mosi(i_mosi),
    .o_cmd(o_cmd), .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .o_busy(o_busy),
    .o_err_abort(o_err_abort), .o_err_cmd(o_err_cmd), .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      if (o_valid && i_ready) acc_q.push_back({o_cmd, o_data});
      if (o_err_abort) n_abort++;
      if (o_err_cmd) n_cmderr++;
      if (o_overrun) n_overrun++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bit_out(input logic b);
    i_mosi = b;
    repeat (3) tick();
    i_sclk = 1'b1;
    repeat (3) tick();
    i_sclk = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) bit_out(v[i]);
  endtask

  task automatic ss_low();
    i_ss_n = 1'b0;
    repeat (4) tick();
  endtask

  task automatic ss_high();
    repeat (4) tick();
    i_ss_n = 1'b1;
    repeat (8) tick();
  endtask

  task automatic frame(input logic [3:0] c, input logic [15:0] p, input int n);
    ss_low();
    send_bits({28'd0, c}, 4);
    send_bits({16'd0, p}, n);
    ss_high();
  endtask

  function automatic logic [31:0] outs();
    return {7'd0, o_cmd, o_data, o_valid, o_busy, o_err_abort, o_err_cmd, o_overrun};
  endfunction

  function automatic logic [31:0] word_at(input int idx);
    return acc_q.size() > idx ? {12'd0, acc_q[idx]} : 32'hFFFF_FFFF;
  endfunction

  initial begin
    int ba, bc, bo, bq;
    vecs[0] = '{4'd0, 6,  16'h002A, 16'h002A};
    vecs[1] = '{4'd1, 6,  16'h003F, 16'h003F};
    vecs[2] = '{4'd2, 6,  16'h0007, 16'h0007};
    vecs[3] = '{4'd3, 12, 16'h0ABC, 16'h0ABC};
    vecs[4] = '{4'd4, 6,  16'h0015, 16'h0015};
    vecs[5] = '{4'd5, 1,  16'h0001, 16'h0001};
    vecs[6] = '{4'd6, 16, 16'hBEEF, 16'hBEEF};
    #1 reset = 1'b1;
    #20;
    check("reset_outputs", outs(), 32'd0);
    #3 reset = 1'b0;
    repeat (3) tick();

    for (int i = 0; i < 7; i++) begin
      bq = acc_q.size(); ba = n_abort; bc = n_cmderr; bo = n_overrun;
      frame(vecs[i].cmd, vecs[i].pay, vecs[i].len);
      check($sformatf("vec%0d_count", i), acc_q.size() - bq, 1);
      check($sformatf("vec%0d_word", i), word_at(bq), {12'd0, vecs[i].cmd, vecs[i].exp});
      check($sformatf("vec%0d_errs", i), (n_abort - ba) + (n_cmderr - bc) + (n_overrun - bo), 0);
    end

    bq = acc_q.size();
    ss_low();
    send_bits(32'h6, 4);
    send_bits(32'hBEEF, 16);
    send_bits(32'h5, 4);
    send_bits(32'h1, 1);
    ss_high();
    check("b2b_count", acc_q.size() - bq, 2);
    check("b2b_first", word_at(bq), 32'h6BEEF);
    check("b2b_second", word_at(bq + 1), 32'h50001);

    i_ready = 1'b0;
    bq = acc_q.size(); bo = n_overrun;
    frame(4'd3, 16'h0ABC, 12);
    frame(4'd0, 16'h0015, 6);
    check("ovr_valid", o_valid, 1);
    check("ovr_held", {o_cmd, o_data}, 32'h30ABC);
    check("ovr_pulses", n_overrun - bo, 1);
    check("ovr_no_accept", acc_q.size() - bq, 0);
    i_ready = 1'b1;
    tick();
    check("ovr_drop_valid", o_valid, 0);
    check("ovr_accepted", word_at(bq), 32'h30ABC);
    check("ovr_data_hold", {o_cmd, o_data}, 32'h30ABC);

    bq = acc_q.size(); ba = n_abort; bc = n_cmderr;
    ss_low();
    send_bits(32'h9, 4);
    repeat (4) tick();
    check("badcmd_pulse", n_cmderr - bc, 1);
    check("badcmd_busy", o_busy, 1);
    send_bits(32'h2AB, 10);
    ss_high();
    check("badcmd_no_abort", n_abort - ba, 0);
    check("badcmd_no_frame", acc_q.size() - bq, 0);
    check("badcmd_idle", o_busy, 0);

    bq = acc_q.size(); ba = n_abort;
    ss_low();
    send_bits(32'h3, 4);
    send_bits(32'h16, 5);
    ss_high();
    check("abort_pulse", n_abort - ba, 1);
    check("abort_no_frame", acc_q.size() - bq, 0);
    frame(4'd1, 16'h003F, 6);
    check("abort_recover", word_at(bq), 32'h1003F);

    i_ready = 1'b0;
    frame(4'd4, 16'h0015, 6);
    check("rst_pre_valid", o_valid, 1);
    ss_low();
    send_bits(32'h2, 4);
    send_bits(32'h5, 3);
    check("rst_pre_busy", o_busy, 1);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("rst_async_outputs", outs(), 32'd0);
    i_ss_n = 1'b1;
    i_ready = 1'b1;
    repeat (3) tick();
    #4 reset = 1'b0;
    repeat (3) tick();
    bq = acc_q.size();
    frame(4'd2, 16'h0007, 6);
    check("rst_fresh_count", acc_q.size() - bq, 1);
    check("rst_fresh_word", word_at(bq), 32'h20007);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
